// File: rtl/reduce_pkg.sv
// Shared definitions for the reduce_stream frame folder: operator codes,
// FSM state encoding and the operator decoder used by the datapath and fold.
package reduce_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BASE_AND = 2'd0,
    BASE_OR  = 2'd1,
    BASE_XOR = 2'd2
  } base_t;

  typedef struct packed {
    base_t base;
    logic  inv;
  } op_dec_t;

  // Split an operator code into the base fold and a final inversion;
  // reserved codes fall back to a plain AND fold.
  function automatic op_dec_t decode_op(input logic [2:0] op);
    op_dec_t d;
    d.base = BASE_AND;
    d.inv  = 1'b0;
    case (op)
      OP_AND:  d.base = BASE_AND;
      OP_OR:   d.base = BASE_OR;
      OP_XOR:  d.base = BASE_XOR;
      OP_NAND: begin d.base = BASE_AND; d.inv = 1'b1; end
      OP_NOR:  begin d.base = BASE_OR;  d.inv = 1'b1; end
      OP_XNOR: begin d.base = BASE_XOR; d.inv = 1'b1; end
      default: d.base = BASE_AND;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reduce_fold.sv
// Combinational scalar reduction of a word with a selectable base operator
// and optional final inversion.
module reduce_fold
  import reduce_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  base_t            base,
  input  logic             inv,
  input  logic [WIDTH-1:0] vec,
  output logic             red
);

  // Reduce the whole vector to one bit, then apply the inversion flag.
  always_comb begin
    red = 1'b0;
    case (base)
      BASE_AND: red = &vec;
      BASE_OR:  red = |vec;
      BASE_XOR: red = ^vec;
      default:  red = &vec;
    endcase
    red = red ^ inv;
  end

endmodule

// File: rtl/reduce_stream.sv
// Folds a valid/ready frame of words with a bitwise operator chosen on the
// first beat and presents the folded vector, scalar reduction, beat count and
// termination flags on a valid/ready result port.
module reduce_stream
  import reduce_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int MAX_WORDS = 16,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_bit,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc,
  output logic             out_bad_op
);

  localparam bit SINGLE_BEAT = (MAX_WORDS == 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       op_q;
  logic             bad_q;
  logic             trunc_q;
  logic             at_limit;
  logic             fold_bit;
  op_dec_t          dec_q;

  assign dec_q    = decode_op(op_q);
  assign cnt_inc  = cnt + CNT_W'(1);
  assign at_limit = (cnt_inc == CNT_W'(MAX_WORDS));

  // Combine the running accumulator with the incoming word using the latched base op.
  always_comb begin
    acc_next = acc;
    case (dec_q.base)
      BASE_AND: acc_next = acc & in_data;
      BASE_OR:  acc_next = acc | in_data;
      BASE_XOR: acc_next = acc ^ in_data;
      default:  acc_next = acc & in_data;
    endcase
  end

  // Datapath registers: first beat seeds the frame, later beats fold in.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      op_q    <= OP_AND;
      bad_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q    <= op;
          bad_q   <= (op > OP_XNOR);
          acc     <= in_data;
          cnt     <= CNT_W'(1);
          trunc_q <= SINGLE_BEAT && !in_last;
        end
        S_ACC: if (in_valid) begin
          acc     <= acc_next;
          cnt     <= cnt_inc;
          trunc_q <= at_limit && !in_last;
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: close on in_last or the beat limit, release on result handshake.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid) state_next = (in_last || SINGLE_BEAT) ? S_DONE : S_ACC;
      S_ACC:  if (in_valid && (in_last || at_limit)) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  reduce_fold #(.WIDTH(WIDTH)) u_fold (
    .base (dec_q.base),
    .inv  (dec_q.inv),
    .vec  (acc),
    .red  (fold_bit)
  );

  // Output decode: result fields are driven only while holding a finished frame.
  always_comb begin
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    out_vec    = '0;
    out_bit    = 1'b0;
    out_count  = '0;
    out_trunc  = 1'b0;
    out_bad_op = 1'b0;
    if (state == S_DONE) begin
      in_ready   = 1'b0;
      out_valid  = 1'b1;
      out_vec    = dec_q.inv ? ~acc : acc;
      out_bit    = fold_bit;
      out_count  = cnt;
      out_trunc  = trunc_q;
      out_bad_op = bad_q;
    end
  end

endmodule

// File: tb/tb_reduce_stream.sv
// Directed self-checking bench for reduce_stream (WIDTH=4, MAX_WORDS=16).
module tb_reduce_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_vec;
  logic       out_bit;
  logic [4:0] out_count;
  logic       out_trunc;
  logic       out_bad_op;

  int n_checks = 0;
  int n_fails  = 0;

  reduce_stream #(.WIDTH(4), .MAX_WORDS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .out_bit    (out_bit),
    .out_count  (out_count),
    .out_trunc  (out_trunc),
    .out_bad_op (out_bad_op)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one beat, confirm it can be taken, and leave the bus idle after the edge.
  task automatic applyStimulus(input logic [2:0] op_v, input logic [3:0] data_v, input logic last_v);
    op       = op_v;
    in_data  = data_v;
    in_last  = last_v;
    in_valid = 1'b1;
    checkOutput("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Compare the full result bundle while a frame is being presented.
  task automatic expectResult(input string tag, input logic [3:0] vec, input logic bit_v,
                              input logic [4:0] count, input logic trunc, input logic bad);
    checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, ".in_ready"},  {31'd0, in_ready},  32'd0);
    checkOutput({tag, ".out_vec"},   {28'd0, out_vec},   {28'd0, vec});
    checkOutput({tag, ".out_bit"},   {31'd0, out_bit},   {31'd0, bit_v});
    checkOutput({tag, ".out_count"}, {27'd0, out_count}, {27'd0, count});
    checkOutput({tag, ".out_trunc"}, {31'd0, out_trunc}, {31'd0, trunc});
    checkOutput({tag, ".out_bad_op"},{31'd0, out_bad_op},{31'd0, bad});
  endtask

  // Check the idle/reset output values.
  task automatic expectIdle(input string tag);
    checkOutput({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, ".out_vec"},   {28'd0, out_vec},   32'd0);
    checkOutput({tag, ".out_bit"},   {31'd0, out_bit},   32'd0);
    checkOutput({tag, ".out_count"}, {27'd0, out_count}, 32'd0);
    checkOutput({tag, ".out_trunc"}, {31'd0, out_trunc}, 32'd0);
    checkOutput({tag, ".out_bad_op"},{31'd0, out_bad_op},32'd0);
  endtask

  // Accept the pending result with a one-cycle out_ready pulse.
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Directed sequence covering every operator, backpressure, truncation and reset.
  initial begin
    rst = 1'b1; op = 3'd0; in_valid = 1'b0; in_data = 4'd0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expectIdle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // AND fold over two beats, result one cycle after the closing beat.
    applyStimulus(3'd0, 4'b1111, 1'b0);
    checkOutput("and.no_early_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(3'd0, 4'b1011, 1'b1);
    expectResult("and2", 4'b1011, 1'b0, 5'd2, 1'b0, 1'b0);
    consume();
    expectIdle("after_and2");

    // OR single-beat frames.
    applyStimulus(3'd1, 4'b0000, 1'b1);
    expectResult("or_zero", 4'b0000, 1'b0, 5'd1, 1'b0, 1'b0);
    consume();
    applyStimulus(3'd1, 4'b0001, 1'b1);
    expectResult("or_one", 4'b0001, 1'b1, 5'd1, 1'b0, 1'b0);
    consume();

    // XOR and XNOR over the same three words.
    applyStimulus(3'd2, 4'b1001, 1'b0);
    applyStimulus(3'd2, 4'b0110, 1'b0);
    applyStimulus(3'd2, 4'b0001, 1'b1);
    expectResult("xor3", 4'b1110, 1'b1, 5'd3, 1'b0, 1'b0);
    consume();
    applyStimulus(3'd5, 4'b1001, 1'b0);
    applyStimulus(3'd5, 4'b0110, 1'b0);
    applyStimulus(3'd5, 4'b0001, 1'b1);
    expectResult("xnor3", 4'b0001, 1'b0, 5'd3, 1'b0, 1'b0);
    consume();

    // NAND, NOR and a reserved code.
    applyStimulus(3'd3, 4'b1111, 1'b0);
    applyStimulus(3'd3, 4'b1111, 1'b1);
    expectResult("nand2", 4'b0000, 1'b0, 5'd2, 1'b0, 1'b0);
    consume();
    applyStimulus(3'd4, 4'b0000, 1'b0);
    applyStimulus(3'd4, 4'b0100, 1'b1);
    expectResult("nor2", 4'b1011, 1'b0, 5'd2, 1'b0, 1'b0);
    consume();
    applyStimulus(3'd7, 4'b1111, 1'b1);
    expectResult("bad_op", 4'b1111, 1'b1, 5'd1, 1'b0, 1'b1);
    consume();

    // Operator change mid-frame is ignored: XOR of 0011 and 0101.
    applyStimulus(3'd2, 4'b0011, 1'b0);
    applyStimulus(3'd0, 4'b0101, 1'b1);
    expectResult("op_change", 4'b0110, 1'b0, 5'd2, 1'b0, 1'b0);
    consume();

    // Backpressure with a beat pending at the source.
    applyStimulus(3'd1, 4'b1010, 1'b1);
    op = 3'd2; in_data = 4'b0110; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expectResult("stall", 4'b1010, 1'b1, 5'd1, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    consume();
    checkOutput("release.in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("release.out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    expectResult("pending_beat", 4'b0110, 1'b0, 5'd1, 1'b0, 1'b0);
    consume();

    // Frame forced closed at sixteen beats; the seventeenth starts a new frame.
    for (int i = 0; i < 16; i++) applyStimulus(3'd0, 4'b1111, 1'b0);
    expectResult("trunc16", 4'b1111, 1'b1, 5'd16, 1'b1, 1'b0);
    consume();
    applyStimulus(3'd0, 4'b1111, 1'b1);
    expectResult("beat17", 4'b1111, 1'b1, 5'd1, 1'b0, 1'b0);
    consume();

    // in_last on the limit beat is a normal close.
    for (int i = 0; i < 15; i++) applyStimulus(3'd1, 4'b0000, 1'b0);
    applyStimulus(3'd1, 4'b0000, 1'b1);
    expectResult("last_at_limit", 4'b0000, 1'b0, 5'd16, 1'b0, 1'b0);
    consume();

    // Reset in the middle of a frame discards it.
    for (int i = 0; i < 3; i++) applyStimulus(3'd7, 4'b0101, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    expectIdle("mid_reset");
    rst = 1'b0;
    applyStimulus(3'd0, 4'b1100, 1'b1);
    expectResult("after_reset", 4'b1100, 1'b0, 5'd1, 1'b0, 1'b0);
    consume();
    expectIdle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reduce_stream.md
Name: reduce_stream

Overview:
- Sequential, parametrised successor to the team's 4-bit reduction-operator selector.
- Accepts a frame of WIDTH-bit words over a valid/ready stream and folds them with a selectable bitwise operator (AND/OR/XOR/NAND/NOR/XNOR).
- Returns the per-bit folded vector and the scalar reduction of the whole frame over a second valid/ready stream.
- Sits between a word source and any consumer needing frame-level parity, all-ones or any-set detection.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- MAX_WORDS, 16, maximum beats per frame before forced termination (>=1).
- CNT_W, $clog2(MAX_WORDS+1), local; width of the beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- op  in  3  operator: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  input word.
- in_last  in  1  final beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_vec  out  WIDTH  folded vector, inverted for NAND/NOR/XNOR.
- out_bit  out  1  scalar reduction of the whole frame.
- out_count  out  CNT_W  beats in frame.
- out_trunc  out  1  frame closed by MAX_WORDS, not by in_last.
- out_bad_op  out  1  reserved op seen; frame processed as AND.

Behaviour:
- Handshakes:
  - A beat is accepted when in_valid && in_ready.
  - A result is taken when out_valid && out_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- First accepted beat (IDLE):
  - Latch op into op_q; assert bad_q if op>5.
  - acc <= in_data; cnt <= 1.
  - Go to DONE if in_last or MAX_WORDS==1, else ACC.
- Later beats (ACC):
  - acc <= acc BASE in_data, where BASE is AND for op_q 0/3/6/7, OR for 1/4, XOR for 2/5.
  - cnt <= cnt+1.
  - Go to DONE when in_last or cnt+1==MAX_WORDS.
- op is sampled only on a frame's first beat; changes mid-frame are ignored.
- Registered outputs, driven in DONE:
  - out_vec = acc, or ~acc for op_q 3/4/5.
  - out_bit = BASE-reduction of acc, inverted for op_q 3/4/5.
  - out_count = cnt.
  - out_trunc = 1 iff DONE was reached via the MAX_WORDS limit without in_last on that beat.
  - out_bad_op = bad_q.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- DONE holds all outputs stable until out_ready; the handshake returns the FSM to IDLE next cycle. There is no bypass, so at least one idle-accept cycle separates frames.
- When in_last coincides with the MAX_WORDS limit, out_trunc=0.
- Beats arriving while in DONE are not accepted (in_ready=0) and remain pending at the source.
- Reset (any state, including mid-frame):
  - State -> IDLE; the partial frame is discarded.
  - acc=0, cnt=0, op_q=0, bad_q=0.
  - Outputs: in_ready=1, out_valid=0, out_vec=0, out_bit=0, out_count=0, out_trunc=0, out_bad_op=0.
- Arithmetic: cnt saturates by construction at MAX_WORDS. acc is exactly WIDTH bits. No X/Z handling is modelled; inputs are assumed 2-state for synthesis.

Decomposition:
- Package reduce_pkg holds:
  - Op code localparams: OP_AND..OP_XNOR.
  - FSM state encoding: S_IDLE, S_ACC, S_DONE.
  - A function mapping op to base op and invert flag.
- One combinational sub-module, reduce_fold: given base op, invert flag and a WIDTH vector, it produces the scalar reduction. Instantiated once on acc.

Test Plan:
1. WIDTH=4, op=0, beats 1111 then 1011(last) -> out_vec=1011, out_bit=0, out_count=2, out_trunc=0, out_valid one cycle after the last beat.
2. op=1, single beat 0000(last) -> out_vec=0000, out_bit=0. Next frame op=1, 0001(last) -> out_bit=1, out_count=1.
3. op=2, beats 1001, 0110, 0001(last) -> out_vec=1110, out_bit=1, out_count=3. Same frame with op=5 -> out_vec=0001, out_bit=0.
4. op=3, beats 1111, 1111(last) -> out_vec=0000, out_bit=0. op=4, beats 0000, 0100(last) -> out_vec=1011, out_bit=0. op=7, beat 1111(last) -> out_bit=1, out_bad_op=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, in_ready=0 and all outputs constant. Then out_ready=1 for one cycle -> IDLE, in_ready=1.
6. MAX_WORDS=16, op=0:
   - Stream 17 beats of 1111, in_last never set -> result after beat 16 with out_count=16, out_trunc=1.
   - Beat 17 starts a new frame.
   - Assert rst after beat 3 of a frame -> all outputs at reset values; the next frame reports out_count starting from 1.
